// File: rtl/bp_be_issue_scoreboard_pkg.sv
// rtl/bp_be_issue_scoreboard_pkg.sv - shared BE scoreboard types: spec FIFO entry and hazard reasons
package bp_be_issue_scoreboard_pkg;

  localparam int bp_be_sb_addr_width_gp = 5;

  typedef struct packed {
    logic [bp_be_sb_addr_width_gp-1:0] rd_addr;
  } bp_be_sb_entry_s;

  typedef enum logic [1:0] {
    e_sb_hz_none,
    e_sb_hz_rs1,
    e_sb_hz_rs2,
    e_sb_hz_full
  } bp_be_sb_hazard_e;

endpackage

// File: rtl/bp_be_scoreboard_spec_fifo.sv
// rtl/bp_be_scoreboard_spec_fifo.sv - in-order FIFO of uncommitted long-latency destinations
module bp_be_scoreboard_spec_fifo
  import bp_be_issue_scoreboard_pkg::*;
#(
  parameter int depth_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           push_v_i,
  input  bp_be_sb_entry_s                push_data_i,
  input  logic                           pop_v_i,
  input  logic                           flush_i,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [depth_p-1:0]             valid_o,
  output logic [$clog2(depth_p)-1:0]     head_idx_o,
  output bp_be_sb_entry_s [depth_p-1:0]  data_o
);

  localparam int ptr_w_lp = $clog2(depth_p);

  logic [ptr_w_lp:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic              push_ok;
  bp_be_sb_entry_s [depth_p-1:0] mem_q;

  assign full_o     = (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]) && (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp]);
  assign empty_o    = (wptr_q == rptr_q);
  assign push_ok    = push_v_i & ~full_o;
  assign count      = wptr_q - rptr_q;
  assign head_idx_o = rptr_q[ptr_w_lp-1:0];
  assign data_o     = mem_q;
  assign wptr_d     = wptr_q + {{ptr_w_lp{1'b0}}, push_ok};

  // Flush leaves the FIFO empty by snapping the read pointer onto the write pointer.
  always_comb begin
    rptr_d = rptr_q + {{ptr_w_lp{1'b0}}, pop_v_i & ~empty_o};
    if (flush_i) rptr_d = wptr_d;
  end

  always_comb begin
    valid_o = '0;
    for (int i = 0; i < depth_p; i++) begin
      valid_o[i] = {1'b0, ptr_w_lp'(i) - rptr_q[ptr_w_lp-1:0]} < count;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[ptr_w_lp-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/bp_be_issue_scoreboard.sv
// rtl/bp_be_issue_scoreboard.sv - issue-stage long-latency hazard scoreboard; optional BP_BE_SCOREBOARD_WAW_EN adds WAW stall
module bp_be_issue_scoreboard
  import bp_be_issue_scoreboard_pkg::*;
#(
  parameter int reg_addr_width_p = bp_be_sb_addr_width_gp,
  parameter int spec_depth_p     = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             isd_v_i,
  input  logic                             isd_rs1_v_i,
  input  logic                             isd_rs2_v_i,
  input  logic [reg_addr_width_p-1:0]      isd_rs1_addr_i,
  input  logic [reg_addr_width_p-1:0]      isd_rs2_addr_i,
  input  logic                             isd_rd_w_v_i,
  input  logic [reg_addr_width_p-1:0]      isd_rd_addr_i,
  input  logic                             isd_long_v_i,
  input  logic                             issue_v_i,
  input  logic                             cmt_long_v_i,
  input  logic                             poison_i,
  input  logic                             iwb_v_i,
  input  logic [reg_addr_width_p-1:0]      iwb_rd_addr_i,
  output logic                             dispatch_v_o,
  output logic                             hazard_rs1_o,
  output logic                             hazard_rs2_o,
  output logic                             hazard_full_o,
  output logic [2**reg_addr_width_p-1:0]   pending_o
);

  localparam int regs_lp = 2**reg_addr_width_p;
  localparam int idx_w_lp = $clog2(spec_depth_p);

  logic [1:0]              rst_sync_q;
  logic                    active;
  logic [regs_lp-1:0]      pending_q, pending_d;
  logic                    issue_en, waw_hz;
  logic                    fifo_full, fifo_empty;
  logic [spec_depth_p-1:0] fifo_valid;
  logic [idx_w_lp-1:0]     fifo_head;
  bp_be_sb_entry_s [spec_depth_p-1:0] fifo_data;
  bp_be_sb_entry_s         push_entry;

  // Reset asserts immediately but releases two clocks later; outputs stay quiet until then.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign active = rst_sync_q[1];

`ifdef BP_BE_SCOREBOARD_WAW_EN
  assign waw_hz = isd_rd_w_v_i & (isd_rd_addr_i != '0) & pending_q[isd_rd_addr_i];
`else
  assign waw_hz = 1'b0;
`endif

  assign hazard_rs1_o  = active & isd_v_i & ((isd_rs1_v_i & pending_q[isd_rs1_addr_i]) | waw_hz);
  assign hazard_rs2_o  = active & isd_v_i & isd_rs2_v_i & pending_q[isd_rs2_addr_i];
  assign hazard_full_o = active & isd_v_i & isd_long_v_i & isd_rd_w_v_i & fifo_full;
  assign dispatch_v_o  = active & isd_v_i & ~poison_i & ~(hazard_rs1_o | hazard_rs2_o | hazard_full_o);
  assign pending_o     = pending_q;

  assign issue_en           = active & issue_v_i & ~poison_i & isd_long_v_i & isd_rd_w_v_i & (isd_rd_addr_i != '0);
  assign push_entry.rd_addr = isd_rd_addr_i;

  bp_be_scoreboard_spec_fifo #(.depth_p(spec_depth_p)) spec_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_v_i    (issue_en),
    .push_data_i (push_entry),
    .pop_v_i     (active & cmt_long_v_i),
    .flush_i     (active & poison_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .valid_o     (fifo_valid),
    .head_idx_o  (fifo_head),
    .data_o      (fifo_data)
  );

  // Commit pop, then poison clear of surviving entries, then writeback clear; a same-cycle issue wins.
  always_comb begin
    pending_d = pending_q;
    if (active && poison_i) begin
      for (int i = 0; i < spec_depth_p; i++) begin
        if (fifo_valid[i] && !(cmt_long_v_i && (fifo_head == idx_w_lp'(i))))
          pending_d[fifo_data[i].rd_addr] = 1'b0;
      end
    end
    if (active && iwb_v_i) pending_d[iwb_rd_addr_i] = 1'b0;
    if (issue_en)          pending_d[isd_rd_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pending_q <= '0;
    else            pending_q <= pending_d;
  end

`ifndef SYNTHESIS
  a_issue_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (active && issue_v_i && !poison_i) |-> dispatch_v_o);
  a_commit_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (active && cmt_long_v_i) |-> !fifo_empty);
`endif

endmodule

// File: tb/tb_bp_be_issue_scoreboard.sv
// tb/tb_bp_be_issue_scoreboard.sv - directed self-checking bench for bp_be_issue_scoreboard
module tb_bp_be_issue_scoreboard;

  logic        clk, rst_n;
  logic        isd_v, rs1_v, rs2_v, rd_w, long_v, issue_v, cmt, poison, iwb_v;
  logic [4:0]  rs1, rs2, rd, iwb_rd;
  logic        dispatch, hz1, hz2, hzf;
  logic [31:0] pending;
  int          checks = 0;
  int          errors = 0;

  bp_be_issue_scoreboard dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .isd_v_i(isd_v), .isd_rs1_v_i(rs1_v), .isd_rs2_v_i(rs2_v),
    .isd_rs1_addr_i(rs1), .isd_rs2_addr_i(rs2),
    .isd_rd_w_v_i(rd_w), .isd_rd_addr_i(rd), .isd_long_v_i(long_v),
    .issue_v_i(issue_v), .cmt_long_v_i(cmt), .poison_i(poison),
    .iwb_v_i(iwb_v), .iwb_rd_addr_i(iwb_rd),
    .dispatch_v_o(dispatch), .hazard_rs1_o(hz1), .hazard_rs2_o(hz2),
    .hazard_full_o(hzf), .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    isd_v = 0; rs1_v = 0; rs2_v = 0; rd_w = 0; long_v = 0; issue_v = 0;
    cmt = 0; poison = 0; iwb_v = 0; rs1 = 0; rs2 = 0; rd = 0; iwb_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1; idle();
  endtask

  task automatic drive_long(input logic [4:0] r);
    isd_v = 1; rd_w = 1; long_v = 1; rd = r; issue_v = 1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    isd_v = 1; rs1_v = 1; rs1 = 5; rd_w = 1; long_v = 1; rd = 5;
    repeat (2) @(posedge clk); #1;
    checks++; if (dispatch !== 1'b0) begin errors++; $display("FAIL reset_dispatch: got %0b expected 0", dispatch); end
    checks++; if ({hz1, hz2, hzf} !== 3'b000) begin errors++; $display("FAIL reset_hazards: got %b expected 000", {hz1, hz2, hzf}); end
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
    @(negedge clk); rst_n = 1;
    repeat (3) @(posedge clk); #1; idle();
    isd_v = 1; #1;
    checks++; if (dispatch !== 1'b1) begin errors++; $display("FAIL reset_release_dispatch: got %0b expected 1", dispatch); end
    tick();
  endtask

  task automatic test_raw();
    drive_long(5); #1;
    checks++; if (dispatch !== 1'b1) begin errors++; $display("FAIL raw_issue_dispatch: got %0b expected 1", dispatch); end
    tick();
    checks++; if (pending !== 32'h20) begin errors++; $display("FAIL raw_pending: got %h expected 00000020", pending); end
    for (int c = 0; c < 3; c++) begin
      isd_v = 1; rs1_v = 1; rs1 = 5; rs2_v = 1; rs2 = 6;
      if (c == 2) begin iwb_v = 1; iwb_rd = 5; cmt = 1; end
      #1;
      checks++; if (hz1 !== 1'b1 || hz2 !== 1'b0 || dispatch !== 1'b0) begin
        errors++; $display("FAIL raw_stall_%0d: got hz1=%0b hz2=%0b disp=%0b expected 1 0 0", c, hz1, hz2, dispatch);
      end
      tick();
    end
    isd_v = 1; rs1_v = 1; rs1 = 5; #1;
    checks++; if (dispatch !== 1'b1 || hz1 !== 1'b0) begin errors++; $display("FAIL raw_release: got disp=%0b hz1=%0b expected 1 0", dispatch, hz1); end
    tick();
  endtask

  task automatic test_full();
    for (int r = 1; r <= 4; r++) begin
      drive_long(5'(r)); #1;
      checks++; if (dispatch !== 1'b1) begin errors++; $display("FAIL full_fill_%0d: got %0b expected 1", r, dispatch); end
      tick();
    end
    checks++; if (pending !== 32'h1E) begin errors++; $display("FAIL full_pending: got %h expected 0000001e", pending); end
    isd_v = 1; rd_w = 1; long_v = 1; rd = 6; #1;
    checks++; if (hzf !== 1'b1 || dispatch !== 1'b0) begin errors++; $display("FAIL full_block: got hzf=%0b disp=%0b expected 1 0", hzf, dispatch); end
    idle(); isd_v = 1; rd_w = 1; rd = 10; #1;
    checks++; if (dispatch !== 1'b1 || hzf !== 1'b0) begin errors++; $display("FAIL full_add_passes: got disp=%0b hzf=%0b expected 1 0", dispatch, hzf); end
    issue_v = 1; cmt = 1;
    tick();
    drive_long(6); #1;
    checks++; if (dispatch !== 1'b1) begin errors++; $display("FAIL full_after_commit: got %0b expected 1", dispatch); end
    tick();
    checks++; if (pending !== 32'h5E) begin errors++; $display("FAIL full_pending2: got %h expected 0000005e", pending); end
    poison = 1;
    tick();
    checks++; if (pending !== 32'h02) begin errors++; $display("FAIL full_poison: got %h expected 00000002", pending); end
    iwb_v = 1; iwb_rd = 1;
    tick();
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL full_drain: got %h expected 0", pending); end
  endtask

  task automatic test_poison();
    drive_long(7); tick();
    drive_long(9); tick();
    cmt = 1; tick();
    poison = 1; isd_v = 1; #1;
    checks++; if (dispatch !== 1'b0) begin errors++; $display("FAIL poison_blocks_dispatch: got %0b expected 0", dispatch); end
    tick();
    checks++; if (pending !== 32'h80) begin errors++; $display("FAIL poison_keep_committed: got %h expected 00000080", pending); end
    for (int r = 16; r < 20; r++) begin drive_long(5'(r)); tick(); end
    isd_v = 1; rd_w = 1; long_v = 1; rd = 20; #1;
    checks++; if (hzf !== 1'b1) begin errors++; $display("FAIL poison_fifo_emptied: got hzf=%0b expected 1", hzf); end
    idle(); cmt = 1; poison = 1;
    tick();
    checks++; if (pending !== 32'h0001_0080) begin errors++; $display("FAIL poison_with_commit: got %h expected 00010080", pending); end
    iwb_v = 1; iwb_rd = 7; tick();
    iwb_v = 1; iwb_rd = 16; tick();
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL poison_drain: got %h expected 0", pending); end
  endtask

  task automatic test_same_cycle();
    drive_long(3); iwb_v = 1; iwb_rd = 3;
    tick();
    checks++; if (pending !== 32'h8) begin errors++; $display("FAIL set_wins_over_wb: got %h expected 00000008", pending); end
    cmt = 1; tick();
    iwb_v = 1; iwb_rd = 3; tick();
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL same_cycle_clear: got %h expected 0", pending); end
    drive_long(0); tick();
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL x0_never_pending: got %h expected 0", pending); end
  endtask

  task automatic test_waw();
    drive_long(8); tick();
    isd_v = 1; rd_w = 1; rd = 8; #1;
`ifdef BP_BE_SCOREBOARD_WAW_EN
    checks++; if (dispatch !== 1'b0 || hz1 !== 1'b1) begin errors++; $display("FAIL waw_stall: got disp=%0b hz1=%0b expected 0 1", dispatch, hz1); end
`else
    checks++; if (dispatch !== 1'b1 || hz1 !== 1'b0) begin errors++; $display("FAIL waw_no_stall: got disp=%0b hz1=%0b expected 1 0", dispatch, hz1); end
`endif
    idle(); cmt = 1; tick();
    iwb_v = 1; iwb_rd = 8; tick();
  endtask

  task automatic test_back_to_back_reset();
    drive_long(13); tick();
    drive_long(14); tick();
    drive_long(15); tick();
    checks++; if (pending !== 32'h0000_E000) begin errors++; $display("FAIL b2b_pending: got %h expected 0000e000", pending); end
    isd_v = 1; rs1_v = 1; rs1 = 13; rs2_v = 1; rs2 = 14; #1;
    checks++; if (hz1 !== 1'b1 || hz2 !== 1'b1) begin errors++; $display("FAIL b2b_both_hazard: got hz1=%0b hz2=%0b expected 1 1", hz1, hz2); end
    #1; rst_n = 0; #1;
    checks++; if (pending !== 32'h0 || dispatch !== 1'b0 || {hz1, hz2, hzf} !== 3'b000) begin
      errors++; $display("FAIL async_reset: got pend=%h disp=%0b hz=%b expected 0 0 000", pending, dispatch, {hz1, hz2, hzf});
    end
    @(negedge clk); rst_n = 1;
    repeat (3) @(posedge clk); #1; idle();
    isd_v = 1; rs1_v = 1; rs1 = 13; rs2_v = 1; rs2 = 14; iwb_v = 1; iwb_rd = 15; #1;
    checks++; if (dispatch !== 1'b1) begin errors++; $display("FAIL reset_discards: got %0b expected 1", dispatch); end
    tick();
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_stale_wb: got %h expected 0", pending); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_full();
    test_poison();
    test_same_cycle();
    test_waw();
    test_back_to_back_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
